muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit and its sequencer for the MIPS datapath.
- Executes mult/multu/div/divu, which the single-cycle ALU cannot finish in one cycle, over multiple clocks.
- Owns the HI/LO result registers and drives a stall (busy) back to the core.
- The core issues an op with a one-cycle start pulse; mfhi/mflo read the HI/LO outputs directly.

---
 rtl/muldiv_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for the MIPS datapath.
// Runs mult/multu/div/divu over several clocks, owns the HI/LO registers
// and raises busy so the core stalls on mfhi/mflo or a new muldiv op.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, op, a, b    one-cycle request (accepted only while idle), opcode
//                      (00 mult, 01 multu, 10 div, 11 divu), rs and rt operands
//   busy, done         busy from the cycle after accept until done; done pulses
//                      for one cycle once hi/lo hold the new result
//   hi, lo             product upper/lower half, or remainder/quotient
//   div_by_zero        sticky flag for a divide by zero; cleared on next accept
//
// Optional feature: define MULDIV_EARLY_TERM_EN to stop a multiply after the
// highest set bit of |b| has been consumed. Results do not change, only the
// multiply latency.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        last_r;     // count value of the final RUN iteration
  logic                 is_div_r;
  logic                 neg_q_r;    // negate product / quotient in FIX
  logic                 neg_r_r;    // negate remainder in FIX
  logic                 dz_r;
  logic [WIDTH-1:0]     a_r;        // raw dividend, reported as HI on divide by zero
  logic [2*WIDTH-1:0]   mcand_r;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]     shreg_r;    // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0]     divisor_r;
  logic [2*WIDTH-1:0]   acc_r;      // product accumulator
  logic [WIDTH-1:0]     rem_r;      // partial remainder

  logic                 signed_op_s;
  logic                 sign_a_s;
  logic                 sign_b_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [2*WIDTH-1:0]   prod_next_s;
  logic [WIDTH:0]       rem_shift_s;
  logic                 div_ge_s;
  logic [WIDTH:0]       rem_next_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quot_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

`ifdef MULDIV_EARLY_TERM_EN
  // Bit index of the most significant set bit (0 when v is zero).
  function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r = CW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  // Operand sign/magnitude, one shift-add or restoring-divide step, FIX corrections.
  always_comb begin
    signed_op_s = ~op[0];
    sign_a_s    = signed_op_s & a[WIDTH-1];
    sign_b_s    = signed_op_s & b[WIDTH-1];
    abs_a_s     = sign_a_s ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    abs_b_s     = sign_b_s ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

    prod_next_s = acc_r + (shreg_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    rem_shift_s = {rem_r, shreg_r[WIDTH-1]};
    div_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
    rem_next_s  = div_ge_s ? (rem_shift_s - {1'b0, divisor_r}) : rem_shift_s;

    prod_fix_s  = neg_q_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    quot_fix_s  = neg_q_r ? (~shreg_r + {{(WIDTH-1){1'b0}}, 1'b1}) : shreg_r;
    rem_fix_s   = neg_r_r ? (~rem_r + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r;
  end

  // Sequencer FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      count_r     <= '0;
      last_r      <= '0;
      is_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dz_r        <= 1'b0;
      a_r         <= '0;
      mcand_r     <= '0;
      shreg_r     <= '0;
      divisor_r   <= '0;
      acc_r       <= '0;
      rem_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            is_div_r    <= op[1];
            neg_q_r     <= sign_a_s ^ sign_b_s;
            neg_r_r     <= sign_a_s;
            a_r         <= a;
            mcand_r     <= {{WIDTH{1'b0}}, abs_a_s};
            divisor_r   <= abs_b_s;
            acc_r       <= '0;
            rem_r       <= '0;
            count_r     <= '0;
            // Multiplier for mult, dividend for div: both live in shreg_r.
            shreg_r     <= op[1] ? abs_a_s : abs_b_s;
            if (op[1] && (b == {WIDTH{1'b0}})) begin
              dz_r    <= 1'b1;
              last_r  <= CW'(WIDTH - 1);
              state_r <= S_FIX;
            end else begin
              dz_r <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
              if (!op[1]) begin
                last_r  <= msb_index(abs_b_s);
                state_r <= (abs_b_s == {WIDTH{1'b0}}) ? S_FIX : S_RUN;
              end else begin
                last_r  <= CW'(WIDTH - 1);
                state_r <= S_RUN;
              end
`else
              last_r  <= CW'(WIDTH - 1);
              state_r <= S_RUN;
`endif
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (is_div_r) begin
            rem_r   <= rem_next_s[WIDTH-1:0];
            shreg_r <= {shreg_r[WIDTH-2:0], div_ge_s};
          end else begin
            acc_r   <= prod_next_s;
            mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
            shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
          end
          count_r <= count_r + CW'(1);
          if (count_r == last_r) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FIX: begin
          if (dz_r) begin
            lo          <= {WIDTH{1'b1}};
            hi          <= a_r;
            div_by_zero <= 1'b1;
          end else if (is_div_r) begin
            lo <= quot_fix_s;
            hi <= rem_fix_s;
          end else begin
            lo <= prod_fix_s[WIDTH-1:0];
            hi <= prod_fix_s[2*WIDTH-1:WIDTH];
          end
          done    <= 1'b1;
          state_r <= S_DONE;
        end
        S_DONE: begin
          // start is ignored here; a new op is accepted the following cycle.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32). Results and latency
// come from a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: results from 64-bit arithmetic, latency from the timing rules.
  task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo,
                       output logic edz, output int elat);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [W-1:0] mag;
    int m;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    edz = 1'b0;
    elat = W + 2;
    case (mop)
      2'd0: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
      2'd1: begin p = {32'd0, ma} * {32'd0, mb}; ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (mb == 32'd0) begin
          edz = 1'b1; elo = 32'hFFFF_FFFF; ehi = ma; elat = 2;
        end else if (mop == 2'd2) begin
          q = sa / sb; r = sa % sb;
          p = q; elo = p[31:0];
          p = r; ehi = p[31:0];
        end else begin
          elo = ma / mb; ehi = ma % mb;
        end
      end
    endcase
`ifdef MULDIV_EARLY_TERM_EN
    if (mop[1] == 1'b0) begin
      mag = (mop == 2'd0 && mb[31]) ? (32'd0 - mb) : mb;
      if (mag == 32'd0) begin
        elat = 2;
      end else begin
        m = 0;
        for (int i = 0; i < W; i++) if (mag[i]) m = i;
        elat = m + 3;
      end
    end
`else
    mag = mb;
    m = 0;
`endif
  endtask

  // Issue one op once the unit is idle, then follow it to done.
  // Reports the done cycle (counted from the accept cycle) and protocol anomalies.
  task automatic exec_op(input logic [1:0] xop, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output int lat, output bit busy_bad, output bit early_change,
                         output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdz);
    logic [W-1:0] phi, plo;
    @(negedge clk);
    for (int g = 0; g < 100 && busy; g++) @(negedge clk);
    op = xop; a = xa; b = xb; start = 1'b1;
    phi = hi; plo = lo;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_bad = 1'b0; early_change = 1'b0;
    rhi = '0; rlo = '0; rdz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        lat = k; rhi = hi; rlo = lo; rdz = div_by_zero;
        break;
      end
      if (hi !== phi || lo !== plo) early_change = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Runs one op and compares every observed aspect to the model.
  task automatic test_op(input string name, input logic [1:0] xop,
                         input logic [W-1:0] xa, input logic [W-1:0] xb);
    int lat, elat; bit bb, ec;
    logic [W-1:0] rhi, rlo, ehi, elo; logic rdz, edz;
    model(xop, xa, xb, ehi, elo, edz, elat);
    exec_op(xop, xa, xb, lat, bb, ec, rhi, rlo, rdz);
    checks += 6;
    if (lat !== elat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
    if (bb !== 1'b0) begin failures++; $display("FAIL %s busy dropped before done", name); end
    if (ec !== 1'b0) begin failures++; $display("FAIL %s hi/lo changed before done", name); end
    if (rhi !== ehi) begin failures++; $display("FAIL %s hi got=%h exp=%h (op=%0d a=%h b=%h)", name, rhi, ehi, xop, xa, xb); end
    if (rlo !== elo) begin failures++; $display("FAIL %s lo got=%h exp=%h (op=%0d a=%h b=%h)", name, rlo, elo, xop, xa, xb); end
    if (rdz !== edz) begin failures++; $display("FAIL %s div_by_zero got=%b exp=%b", name, rdz, edz); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 1;
    if ({busy, done, hi, lo, div_by_zero} !== {2'b00, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h dz=%b exp all zero", busy, done, hi, lo, div_by_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    test_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    test_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    test_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    test_op("div_7_neg2", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE);
    test_op("mult_zero_b", 2'd0, 32'h1234_5678, 32'h0000_0000);
  endtask

  task automatic test_div_by_zero();
    test_op("divu_zero", 2'd3, 32'h1234_5678, 32'h0000_0000);
    repeat (3) @(negedge clk);
    checks += 1;
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_sticky got=%b exp=1", div_by_zero); end
    test_op("dz_cleared", 2'd1, 32'h0000_0003, 32'h0000_0005);
  endtask

  task automatic test_ignore_start();
    int lat; bit early;
    logic [W-1:0] phi, plo, ehi, elo; logic edz; int elat;
    model(2'd3, 32'hDEAD_BEEF, 32'h0000_1234, ehi, elo, edz, elat);
    @(negedge clk);
    for (int g = 0; g < 100 && busy; g++) @(negedge clk);
    op = 2'd3; a = 32'hDEAD_BEEF; b = 32'h0000_1234; start = 1'b1;
    phi = hi; plo = lo;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; early = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin lat = k; break; end
      if (hi !== phi || lo !== plo) early = 1'b1;
      if (k == 5) begin op = 2'd0; a = 32'h0000_0011; b = 32'h0000_0022; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks += 4;
    if (lat !== elat) begin failures++; $display("FAIL ignore_start latency got=%0d exp=%0d", lat, elat); end
    if (early !== 1'b0) begin failures++; $display("FAIL ignore_start hi/lo changed before done"); end
    if (hi !== ehi) begin failures++; $display("FAIL ignore_start hi got=%h exp=%h", hi, ehi); end
    if (lo !== elo) begin failures++; $display("FAIL ignore_start lo got=%h exp=%h", lo, elo); end
  endtask

  task automatic test_reset_mid();
    test_op("pre_reset_dz", 2'd3, 32'hCAFE_0001, 32'h0000_0000);
    @(negedge clk);
    op = 2'd1; a = 32'h0000_0100; b = 32'h8000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks += 1;
    if ({busy, done, hi, lo, div_by_zero} !== {2'b00, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h dz=%b exp all zero", busy, done, hi, lo, div_by_zero);
    end
    test_op("post_reset_6x7", 2'd1, 32'd6, 32'd7);
  endtask

  task automatic test_back_to_back();
    int lat; bit bb, ec; logic [W-1:0] rhi, rlo; logic rdz;
    // start held through the DONE cycle must not launch a new op there.
    exec_op(2'd1, 32'd9, 32'd9, lat, bb, ec, rhi, rlo, rdz);
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL b2b done_pulse got=%b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b start_in_done got busy=%b exp=0", busy); end
    test_op("b2b_next", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_op("b2b_next2", 2'd2, 32'h7FFF_FFFF, 32'h0000_0003);
  endtask

  task automatic test_random();
    logic [1:0] rop; logic [W-1:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = rb >> $urandom_range(1, 31);
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      test_op("random", rop, ra, rb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
